// File: rtl/alu_result_acc.sv
// Burst accumulator for the 9-bit signed ALU result stream with a valid/ready output.
// Define ALU_RESULT_ACC_SAT_EN to clamp the accumulator on overflow instead of wrapping.
module alu_result_acc #(
  parameter int ACC_W = 16,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [8:0]       in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic             drop_err
);

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(BURST - 1);

`ifdef ALU_RESULT_ACC_SAT_EN
  localparam logic [ACC_W-1:0] SUM_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SUM_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  function automatic logic [ACC_W-1:0] clamp_limit(input logic neg_dir);
    if (neg_dir) begin
      return SUM_MIN;
    end else begin
      return SUM_MAX;
    end
  endfunction
`endif

  // Signed overflow: operands agree in sign and the sum disagrees.
  function automatic logic add_overflow(input logic [ACC_W-1:0] a,
                                        input logic [ACC_W-1:0] b,
                                        input logic [ACC_W-1:0] s);
    return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
  endfunction

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   out_sum_q, out_sum_d;
  logic               out_ovf_q, out_ovf_d;
  logic               drop_err_q, drop_err_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [ACC_W-1:0]   sext_s;
  logic [ACC_W-1:0]   raw_sum_s;
  logic               add_ovf_s;
  logic [ACC_W-1:0]   acc_add_s;

  // Datapath: sign-extend the sample, add, detect overflow, apply wrap/clamp policy.
  always_comb begin
    sext_s    = {{(ACC_W-9){in_data[8]}}, in_data};
    raw_sum_s = acc_q + sext_s;
    add_ovf_s = add_overflow(acc_q, sext_s, raw_sum_s);
`ifdef ALU_RESULT_ACC_SAT_EN
    if (add_ovf_s) begin
      acc_add_s = clamp_limit(acc_q[ACC_W-1]);
    end else begin
      acc_add_s = raw_sum_s;
    end
`else
    acc_add_s = raw_sum_s;
`endif
  end

  // Next-state and output logic for the ACC/HOLD controller.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    out_sum_d  = out_sum_q;
    out_ovf_d  = out_ovf_q;
    drop_err_d = drop_err_q;

    case (state_q)
      ST_ACC: begin
        if (in_valid) begin
          acc_d = acc_add_s;
          ovf_d = ovf_q | add_ovf_s;
          if (cnt_q == LAST_CNT) begin
            out_sum_d = acc_add_s;
            out_ovf_d = ovf_q | add_ovf_s;
            state_d   = ST_HOLD;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          acc_d = acc_q;
        end
      end
      ST_HOLD: begin
        // Anything offered while stalled is lost; remember that forever.
        if (in_valid) begin
          drop_err_d = 1'b1;
        end else begin
          drop_err_d = drop_err_q;
        end
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = 8'd0;
          ovf_d   = 1'b0;
          state_d = ST_ACC;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_ACC;
      end
    endcase

    in_ready_d  = (state_d == ST_ACC);
    out_valid_d = (state_d == ST_HOLD);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      cnt_q       <= 8'd0;
      ovf_q       <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
      drop_err_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
      drop_err_q  <= drop_err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;
  assign drop_err  = drop_err_q;

endmodule

// File: tb/tb_alu_result_acc.sv
// Self-checking bench for alu_result_acc: directed vector table, hand sequences for
// reset corners, and randomized traffic against a burst-level reference model.
module tb_alu_result_acc;

  localparam int BURST = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [8:0]  in_data;
  logic        out_ready;

  logic        ir0, ov0, ovf0, drop0;
  logic [15:0] sum0;
  logic        ir1, ov1, ovf1, drop1;
  logic [9:0]  sum1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_result_acc #(.ACC_W(16), .BURST(BURST)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir0), .out_valid(ov0), .out_ready(out_ready),
    .out_sum(sum0), .out_ovf(ovf0), .drop_err(drop0)
  );

  alu_result_acc #(.ACC_W(10), .BURST(BURST)) u_dut10 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir1), .out_valid(ov1), .out_ready(out_ready),
    .out_sum(sum1), .out_ovf(ovf1), .drop_err(drop1)
  );

  typedef struct {
    int v; int d; int r;
    int e_ov; int e_ir; int e_sum; int e_ovf; int e_drop;
  } vec_t;

  vec_t tbl[$];

  // Reference model state (per DUT: 0 = 16-bit, 1 = 10-bit)
  bit     pend[2];
  bit     mdrop[2];
  bit     movf[2];
  bit     sum_known[2];
  longint msum[2];
  longint smp[2][BURST];
  int     n[2];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic void add_row(int v, int d, int r, int e_ov, int e_ir,
                                  int e_sum, int e_ovf, int e_drop);
    vec_t x;
    x = '{v, d, r, e_ov, e_ir, e_sum, e_ovf, e_drop};
    tbl.push_back(x);
  endfunction

  task automatic drive(input int v, input int d, input int r);
    in_valid  = v[0];
    in_data   = 9'(d);
    out_ready = r[0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sum the stored burst with true integer arithmetic, applying wrap or clamp per add.
  function automatic void burst_calc(input int m, input int w,
                                     output longint s, output bit o);
    longint hi, lo, r, t;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -hi - 1;
    r = 0;
    o = 1'b0;
    for (int i = 0; i < BURST; i++) begin
      t = r + smp[m][i];
      if (t > hi || t < lo) begin
        o = 1'b1;
`ifdef ALU_RESULT_ACC_SAT_EN
        r = (t > hi) ? hi : lo;
`else
        r = (t > hi) ? t - (longint'(1) << w) : t + (longint'(1) << w);
`endif
      end else begin
        r = t;
      end
    end
    s = r;
  endfunction

  task automatic model_edge(input int m, input int w);
    longint s;
    bit o;
    if (!rst) begin
      pend[m] = 1'b0; n[m] = 0; mdrop[m] = 1'b0;
      msum[m] = 0; movf[m] = 1'b0; sum_known[m] = 1'b1;
    end else if (!pend[m]) begin
      sum_known[m] = 1'b0;
      if (in_valid) begin
        smp[m][n[m]] = longint'($signed(in_data));
        n[m]++;
        if (n[m] == BURST) begin
          burst_calc(m, w, s, o);
          msum[m] = s; movf[m] = o; pend[m] = 1'b1; n[m] = 0;
        end
      end
    end else begin
      if (in_valid) mdrop[m] = 1'b1;
      if (out_ready) pend[m] = 1'b0;
    end
  endtask

  task automatic model_check(input int m);
    logic ir, ov, ovf, drop;
    longint s;
    if (m == 0) begin
      ir = ir0; ov = ov0; ovf = ovf0; drop = drop0; s = longint'($signed(sum0));
    end else begin
      ir = ir1; ov = ov1; ovf = ovf1; drop = drop1; s = longint'($signed(sum1));
    end
    chk(m == 0 ? "rnd16_out_valid" : "rnd10_out_valid", longint'(ov), longint'(pend[m]));
    chk(m == 0 ? "rnd16_in_ready" : "rnd10_in_ready", longint'(ir), longint'(!pend[m]));
    chk(m == 0 ? "rnd16_drop_err" : "rnd10_drop_err", longint'(drop), longint'(mdrop[m]));
    if (pend[m] || sum_known[m]) begin
      chk(m == 0 ? "rnd16_out_sum" : "rnd10_out_sum", s, msum[m]);
      chk(m == 0 ? "rnd16_out_ovf" : "rnd10_out_ovf", longint'(ovf), longint'(movf[m]));
    end
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 0);
    tick();
    chk("reset_in_ready", longint'(ir0), 1);
    chk("reset_out_valid", longint'(ov0), 0);
    chk("reset_out_sum", longint'($signed(sum0)), 0);
    chk("reset_out_ovf", longint'(ovf0), 0);
    chk("reset_drop_err", longint'(drop0), 0);
    rst = 1'b1;

    // Basic sum, then backpressure with drops, then sparse input
    add_row(1, 10, 1, 0, 1, 0, 0, 0);
    add_row(1, -3, 1, 0, 1, 0, 0, 0);
    add_row(1, 255, 1, 0, 1, 0, 0, 0);
    add_row(1, -256, 1, 1, 0, 6, 0, 0);
    add_row(0, 0, 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) add_row(1, 2, 1, 0, 1, 0, 0, 0);
    add_row(1, 2, 1, 1, 0, 8, 0, 0);
    for (int i = 0; i < 3; i++) add_row(1, 7, 0, 1, 0, 8, 0, 1);
    add_row(0, 0, 1, 0, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) add_row(1, 1, 0, 0, 1, 0, 0, 1);
    add_row(1, 1, 0, 1, 0, 4, 0, 1);
    add_row(0, 0, 1, 0, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      add_row(1, 5, 1, 0, 1, 0, 0, 1);
      add_row(0, 0, 1, 0, 1, 0, 0, 1);
      add_row(0, 0, 1, 0, 1, 0, 0, 1);
    end
    add_row(1, 5, 1, 1, 0, 20, 0, 1);
    add_row(0, 0, 1, 0, 1, 0, 0, 1);

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].r);
      tick();
      chk($sformatf("vec%0d_out_valid", i), longint'(ov0), tbl[i].e_ov);
      chk($sformatf("vec%0d_in_ready", i), longint'(ir0), tbl[i].e_ir);
      chk($sformatf("vec%0d_drop_err", i), longint'(drop0), tbl[i].e_drop);
      if (tbl[i].e_ov != 0) begin
        chk($sformatf("vec%0d_out_sum", i), longint'($signed(sum0)), tbl[i].e_sum);
        chk($sformatf("vec%0d_out_ovf", i), longint'(ovf0), tbl[i].e_ovf);
      end
    end

    // Overflow on the 10-bit instance: 255 four times
    rst = 1'b0; drive(0, 0, 0); tick(); rst = 1'b1;
    for (int i = 0; i < BURST; i++) begin
      drive(1, 255, 0);
      tick();
    end
`ifdef ALU_RESULT_ACC_SAT_EN
    chk("ovf10_out_sum", longint'($signed(sum1)), 511);
`else
    chk("ovf10_out_sum", longint'($signed(sum1)), -4);
`endif
    chk("ovf10_out_ovf", longint'(ovf1), 1);
    chk("ovf10_out_valid", longint'(ov1), 1);

    // Reset mid-burst discards the partial sum
    rst = 1'b0; drive(0, 0, 0); tick(); rst = 1'b1;
    drive(1, 100, 0); tick();
    drive(1, 100, 0); tick();
    chk("rstmid_no_output", longint'(ov0), 0);
    rst = 1'b0; drive(0, 0, 0); tick(); rst = 1'b1;
    chk("rstmid_in_ready", longint'(ir0), 1);
    chk("rstmid_out_sum", longint'($signed(sum0)), 0);
    for (int i = 1; i <= BURST; i++) begin
      drive(1, i, 0);
      tick();
      chk($sformatf("rstmid_valid_%0d", i), longint'(ov0), (i == BURST) ? 1 : 0);
    end
    chk("rstmid_out_sum_final", longint'($signed(sum0)), 10);
    chk("rstmid_drop_err", longint'(drop0), 0);

    // Reset during HOLD beats a simultaneous handshake and drop
    rst = 1'b0; drive(1, 3, 1); tick(); rst = 1'b1;
    chk("rsthold_out_valid", longint'(ov0), 0);
    chk("rsthold_out_sum", longint'($signed(sum0)), 0);
    chk("rsthold_in_ready", longint'(ir0), 1);
    chk("rsthold_drop_err", longint'(drop0), 0);

    // Randomized traffic against the reference model
    rst = 1'b0;
    drive(0, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      model_edge(0, 16);
      model_edge(1, 10);
      #1;
      model_check(0);
      model_check(1);
      rst       = ($urandom_range(0, 99) != 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = 9'($urandom);
      out_ready = 1'($urandom_range(0, 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
